// File: rtl/ls161_timer_ctrl.sv
// rtl/ls161_timer_ctrl.sv - sequencer for a cascaded LS161-style counter chain timer
//
// Purpose:
//   Drives sync clear, parallel load, ENP and ENT of a chain of WIDTH/4
//   4-bit synchronous counter slices. It watches the chain's top-slice RCO
//   so the chain acts as a one-shot or periodic programmable timer.
//   All outputs are registered Moore outputs, updated on the same edge as the state.
//
// Ports:
//   clk_i            clock, rising edge
//   clr_ni           asynchronous active-low reset
//   start_i          begin timing (sampled only in IDLE)
//   stop_i           abort from any state; wins over start_i
//   hold_i           pause counting (drops chain_enp_o only)
//   mode_periodic_i  1 = reload and repeat on terminal count, 0 = one-shot
//   preset_i         load value, latched at start
//   max_periods_i    periodic repeat limit, latched at start, 0 = unlimited
//   tc_i             chain RCO from the top slice
//   chain_d_o        parallel data to the chain (latched preset)
//   chain_load_n_o   chain LOAD_n
//   chain_clr_n_o    chain synchronous clear, active low
//   chain_enp_o      chain ENP
//   chain_ent_o      chain ENT
//   busy_o           high in LOAD and RUN
//   tick_o           one-cycle pulse per terminal count
//   done_o           one-cycle pulse at normal completion
//   period_cnt_o     ticks since last start, saturating at 255

module ls161_timer_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             clr_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             hold_i,
  input  logic             mode_periodic_i,
  input  logic [WIDTH-1:0] preset_i,
  input  logic [7:0]       max_periods_i,
  input  logic             tc_i,
  output logic [WIDTH-1:0] chain_d_o,
  output logic             chain_load_n_o,
  output logic             chain_clr_n_o,
  output logic             chain_enp_o,
  output logic             chain_ent_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o,
  output logic [7:0]       period_cnt_o
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_LOAD  = 2'd2,
    S_RUN   = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] chain_d_q;
  logic             load_n_q;
  logic             clr_n_q;
  logic             enp_q;
  logic             ent_q;
  logic             busy_q;
  logic             tick_q;
  logic             done_q;
  logic [7:0]       period_cnt_q;
  logic [7:0]       max_periods_q;
  logic             periodic_q;

  // Unsaturated increment kept 9 bits wide so the repeat-limit compare
  // never wraps when period_cnt is already at 255.
  logic [8:0] cnt_plus1_d;
  logic [7:0] cnt_sat_d;
  logic       reload_d;

  assign cnt_plus1_d = {1'b0, period_cnt_q} + 9'd1;
  assign cnt_sat_d   = cnt_plus1_d[8] ? 8'hFF : cnt_plus1_d[7:0];
  assign reload_d    = periodic_q &&
                       ((max_periods_q == 8'd0) || (cnt_plus1_d < {1'b0, max_periods_q}));

  always_ff @(posedge clk_i or negedge clr_ni) begin
    if (!clr_ni) begin
      state_q       <= S_CLEAR;
      chain_d_q     <= '0;
      load_n_q      <= 1'b1;
      clr_n_q       <= 1'b0;
      enp_q         <= 1'b0;
      ent_q         <= 1'b0;
      busy_q        <= 1'b0;
      tick_q        <= 1'b0;
      done_q        <= 1'b0;
      period_cnt_q  <= 8'd0;
      max_periods_q <= 8'd0;
      periodic_q    <= 1'b0;
    end else begin
      // Pulses default low; only the RUN terminal-count branch raises them.
      tick_q <= 1'b0;
      done_q <= 1'b0;

      if (stop_i) begin
        // Abort: clear the chain for as long as stop is held; period_cnt is kept.
        state_q  <= S_CLEAR;
        clr_n_q  <= 1'b0;
        load_n_q <= 1'b1;
        enp_q    <= 1'b0;
        ent_q    <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          S_CLEAR: begin
            state_q  <= S_IDLE;
            clr_n_q  <= 1'b1;
            load_n_q <= 1'b1;
            enp_q    <= 1'b0;
            ent_q    <= 1'b0;
            busy_q   <= 1'b0;
          end

          S_IDLE: begin
            clr_n_q  <= 1'b1;
            load_n_q <= 1'b1;
            enp_q    <= 1'b0;
            ent_q    <= 1'b0;
            busy_q   <= 1'b0;
            if (start_i) begin
              state_q       <= S_LOAD;
              load_n_q      <= 1'b0;
              busy_q        <= 1'b1;
              chain_d_q     <= preset_i;
              max_periods_q <= max_periods_i;
              periodic_q    <= mode_periodic_i;
              period_cnt_q  <= 8'd0;
            end
          end

          S_LOAD: begin
            // The chain takes chain_d on this edge; counting starts from the next.
            state_q  <= S_RUN;
            clr_n_q  <= 1'b1;
            load_n_q <= 1'b1;
            ent_q    <= 1'b1;
            enp_q    <= ~hold_i;
            busy_q   <= 1'b1;
          end

          S_RUN: begin
            clr_n_q  <= 1'b1;
            load_n_q <= 1'b1;
            ent_q    <= 1'b1;
            enp_q    <= ~hold_i;
            busy_q   <= 1'b1;
            // RCO is only honoured while the chain is actually counting.
            if (tc_i && !hold_i) begin
              tick_q       <= 1'b1;
              period_cnt_q <= cnt_sat_d;
              enp_q        <= 1'b0;
              ent_q        <= 1'b0;
              if (reload_d) begin
                state_q  <= S_LOAD;
                load_n_q <= 1'b0;
              end else begin
                state_q <= S_IDLE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end

          default: begin
            state_q  <= S_CLEAR;
            clr_n_q  <= 1'b0;
            load_n_q <= 1'b1;
            enp_q    <= 1'b0;
            ent_q    <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign chain_d_o      = chain_d_q;
  assign chain_load_n_o = load_n_q;
  assign chain_clr_n_o  = clr_n_q;
  assign chain_enp_o    = enp_q;
  assign chain_ent_o    = ent_q;
  assign busy_o         = busy_q;
  assign tick_o         = tick_q;
  assign done_o         = done_q;
  assign period_cnt_o   = period_cnt_q;

endmodule

// File: tb/tb_ls161_timer_ctrl.sv
// tb/tb_ls161_timer_ctrl.sv - directed self-checking bench for ls161_timer_ctrl

module tb_ls161_timer_ctrl;

  logic       clk;
  logic       clr_n;
  logic       start;
  logic       stop;
  logic       hold;
  logic       mode_periodic;
  logic [7:0] preset;
  logic [7:0] max_periods;
  logic       tc;
  logic [7:0] chain_d;
  logic       chain_load_n;
  logic       chain_clr_n;
  logic       chain_enp;
  logic       chain_ent;
  logic       busy;
  logic       tick;
  logic       done;
  logic [7:0] period_cnt;

  logic       tc_force;
  logic [7:0] chain_q = 8'd0;

  int checks = 0;
  int errors = 0;

  ls161_timer_ctrl #(.WIDTH(8)) dut (
    .clk_i           (clk),
    .clr_ni          (clr_n),
    .start_i         (start),
    .stop_i          (stop),
    .hold_i          (hold),
    .mode_periodic_i (mode_periodic),
    .preset_i        (preset),
    .max_periods_i   (max_periods),
    .tc_i            (tc),
    .chain_d_o       (chain_d),
    .chain_load_n_o  (chain_load_n),
    .chain_clr_n_o   (chain_clr_n),
    .chain_enp_o     (chain_enp),
    .chain_ent_o     (chain_ent),
    .busy_o          (busy),
    .tick_o          (tick),
    .done_o          (done),
    .period_cnt_o    (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two cascaded 4-bit synchronous counters behave as one 8-bit counter.
  always @(posedge clk) begin
    if (!chain_clr_n)       chain_q <= 8'd0;
    else if (!chain_load_n) chain_q <= chain_d;
    else if (chain_enp && chain_ent) chain_q <= chain_q + 8'd1;
  end
  assign tc = tc_force | ((&chain_q) & chain_ent);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int first_tick;
  int first_done;
  int ntick;
  int ndone;
  int tick_at[4];

  initial begin
    clr_n = 1'b0; start = 1'b0; stop = 1'b0; hold = 1'b0; mode_periodic = 1'b0;
    preset = 8'h00; max_periods = 8'd0; tc_force = 1'b0;

    // 1. Reset values, then a single cycle of chain clear after release
    step(); step();
    chk("rst_clr_n", chain_clr_n, 1'b0);
    chk("rst_load_n", chain_load_n, 1'b1);
    chk("rst_enp_ent", {chain_enp, chain_ent}, 2'b00);
    chk("rst_busy_tick_done", {busy, tick, done}, 3'b000);
    chk("rst_chain_d", chain_d, 8'h00);
    chk("rst_period_cnt", period_cnt, 8'd0);
    clr_n = 1'b1;
    chk("rel_clr_n_low", chain_clr_n, 1'b0);
    step();
    chk("idle_clr_n", chain_clr_n, 1'b1);
    step();
    chk("idle_clr_n_stays", chain_clr_n, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // 2. One-shot, preset F0: tick and done 18 cycles after start is applied
    preset = 8'hF0; mode_periodic = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("os_load_n_low", chain_load_n, 1'b0);
    chk("os_busy_load", busy, 1'b1);
    chk("os_enp_load", chain_enp, 1'b0);
    step();
    chk("os_load_n_high", chain_load_n, 1'b1);
    chk("os_enp_ent_run", {chain_enp, chain_ent}, 2'b11);
    chk("os_chain_d", chain_d, 8'hF0);
    first_tick = 0; first_done = 0;
    for (int c = 3; c <= 40; c++) begin
      step();
      if (tick && first_tick == 0) first_tick = c;
      if (done && first_done == 0) first_done = c;
    end
    chk("os_tick_cycle", first_tick, 18);
    chk("os_done_cycle", first_done, 18);
    chk("os_busy_after", busy, 1'b0);
    chk("os_period_cnt", period_cnt, 8'd1);

    // 3. Periodic FC, limit 3; mid-run start pulses and input changes are ignored
    preset = 8'hFC; mode_periodic = 1'b1; max_periods = 8'd3;
    start = 1'b1;
    ntick = 0; ndone = 0; first_done = 0;
    for (int i = 0; i < 4; i++) tick_at[i] = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) begin
        preset = 8'h11; max_periods = 8'd1; mode_periodic = 1'b0;
      end
      start = (c == 3 || c == 8);
      if (tick) begin
        if (ntick < 4) tick_at[ntick] = c;
        ntick++;
      end
      if (done) begin
        ndone++;
        if (first_done == 0) first_done = c;
      end
      if (c == 8) chk("per_chain_d_reload", chain_d, 8'hFC);
    end
    start = 1'b0;
    chk("per_ntick", ntick, 3);
    chk("per_tick1", tick_at[0], 6);
    chk("per_tick2", tick_at[1], 11);
    chk("per_tick3", tick_at[2], 16);
    chk("per_ndone", ndone, 1);
    chk("per_done_cycle", first_done, 16);
    chk("per_period_cnt", period_cnt, 8'd3);
    chk("per_busy_after", busy, 1'b0);

    // 3b. Unlimited periodic run saturates period_cnt; then stop during RUN
    preset = 8'hFC; mode_periodic = 1'b1; max_periods = 8'd0;
    start = 1'b1;
    ntick = 0; ndone = 0;
    for (int c = 1; c <= 1600; c++) begin
      step();
      start = 1'b0;
      if (tick) ntick++;
      if (done) ndone++;
    end
    chk("unl_ntick", ntick, 319);
    chk("unl_ndone", ndone, 0);
    chk("unl_period_cnt", period_cnt, 8'd255);
    chk("unl_busy", busy, 1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_clr_n", chain_clr_n, 1'b0);
    chk("stop_busy_tick_done", {busy, tick, done}, 3'b000);
    chk("stop_enp_ent", {chain_enp, chain_ent}, 2'b00);
    chk("stop_period_cnt_kept", period_cnt, 8'd255);
    step();
    chk("stop_to_idle", chain_clr_n, 1'b1);
    chk("stop_idle_busy", busy, 1'b0);

    // 4. Hold for 7 cycles mid-run with tc forced high: done delayed to 25
    preset = 8'hF0; mode_periodic = 1'b0; max_periods = 8'd0;
    start = 1'b1;
    first_tick = 0; first_done = 0;
    for (int c = 1; c <= 40; c++) begin
      step();
      start = 1'b0;
      if (tick && first_tick == 0) first_tick = c;
      if (done && first_done == 0) first_done = c;
      if (c == 6) begin
        chk("hold_enp_low", chain_enp, 1'b0);
        chk("hold_ent_high", chain_ent, 1'b1);
      end
      if (c == 12) chk("hold_enp_back", chain_enp, 1'b1);
      if (c == 4) begin hold = 1'b1; tc_force = 1'b1; end
      if (c == 11) begin hold = 1'b0; tc_force = 1'b0; end
    end
    chk("hold_tick_cycle", first_tick, 25);
    chk("hold_done_cycle", first_done, 25);

    // 5. Same-cycle start and stop in IDLE never enters LOAD
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    chk("ss_clr_n", chain_clr_n, 1'b0);
    chk("ss_load_n", chain_load_n, 1'b1);
    chk("ss_busy", busy, 1'b0);
    step();
    chk("ss_idle_clr_n", chain_clr_n, 1'b1);
    chk("ss_idle_load_n", chain_load_n, 1'b1);
    step();
    chk("ss_no_load", {chain_load_n, busy}, 2'b10);

    // 6. Asynchronous reset mid-run takes effect without a clock edge
    preset = 8'hF0; mode_periodic = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("ar_busy_before", busy, 1'b1);
    #2;
    clr_n = 1'b0;
    #1;
    chk("ar_clr_n", chain_clr_n, 1'b0);
    chk("ar_busy", busy, 1'b0);
    chk("ar_enp_ent", {chain_enp, chain_ent}, 2'b00);
    chk("ar_chain_d", chain_d, 8'h00);
    chk("ar_period_cnt", period_cnt, 8'd0);
    chk("ar_load_n", chain_load_n, 1'b1);
    step();
    chk("ar_chain_cleared", chain_q, 8'h00);
    clr_n = 1'b1;
    step();
    chk("ar_idle", {chain_clr_n, busy}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
